// File: rtl/soc_mmio_pkg.sv
// Shared definitions for memory-mapped peripherals on CPU data-bus port B.
// Contents:
//   ADDR_DATA / ADDR_STATUS - UART TX register addresses (I/O space above 0xFFFF)
//   ST_*                    - bit positions inside the UART TX status word
//   tx_state_e              - UART transmitter FSM states
package soc_mmio_pkg;

   localparam logic [31:0] ADDR_DATA   = 32'd65544;
   localparam logic [31:0] ADDR_STATUS = 32'd65548;

   // Status word layout; bits [31:9] read as zero.
   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVERFLOW  = 2;
   localparam int ST_ACTIVE    = 3;
   localparam int ST_COUNT_LSB = 4;
   localparam int ST_COUNT_W   = 5;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Data-bus port B signal bundle between the CPU and a memory-mapped slave.
// Signals:
//   addr_b     - bus address (master -> slave)
//   data_b_in  - write data (master -> slave)
//   data_b_we  - write enable (master -> slave)
//   data_b     - registered read data (slave -> master)
//   strobe_b   - registered read strobe (slave -> master)
interface uart_tx_mmio_if;

   logic [31:0] addr_b;
   logic [31:0] data_b_in;
   logic        data_b_we;
   logic [31:0] data_b;
   logic        strobe_b;

   modport master (
      output addr_b, data_b_in, data_b_we,
      input  data_b, strobe_b
   );

   modport slave (
      input  addr_b, data_b_in, data_b_we,
      output data_b, strobe_b
   );

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter.
// Ports:
//   clk, rst   - clock and asynchronous active-low reset
//   push, din  - write request and byte; accepted when not full, or when full
//                together with a pop in the same cycle
//   pop, dout  - read request and head byte (dout shows the head combinationally)
//   empty, full, count - occupancy; count is one bit wider than the pointers
module uart_tx_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int              AW         = $clog2(DEPTH);
   localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   count_reg, count_next;
   logic          do_push, do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == FULL_COUNT);
   assign count   = count_reg;
   assign dout    = mem[rd_ptr_reg];

   assign do_pop  = pop & ~empty;
   // A pop frees the slot this cycle, so a push into a full FIFO still lands.
   assign do_push = push & (~full | do_pop);

   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + (AW + 1)'(1);
         2'b01:   count_next = count_reg - (AW + 1)'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_next;
      end
   end

   // Storage is not reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 serial transmitter on CPU data-bus port B.
// Ports:
//   clk, rst - clock and asynchronous active-low reset
//   bus      - port B slave: writes to ADDR_DATA queue a byte, writes to
//              ADDR_STATUS clear overflow, reads of ADDR_STATUS return the
//              status word on data_b one cycle later with strobe_b
//   tx       - registered serial output, idles high
//   busy     - FIFO non-empty or a frame in progress
module uart_tx_mmio
   import soc_mmio_pkg::*;
#(
   parameter int CLK_DIV    = 434,
   parameter int FIFO_DEPTH = 16
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_mmio_if.slave  bus,
   output logic           tx,
   output logic           busy
);

   localparam int            BW        = $clog2(CLK_DIV);
   localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

   tx_state_e     state_reg, state_next;
   logic [BW-1:0] baud_reg, baud_next;
   logic [2:0]    bit_reg, bit_next;
   logic [7:0]    shift_reg, shift_next;
   logic          tx_reg, tx_next;
   logic          overflow_reg, overflow_next;
   logic [31:0]   data_b_reg;
   logic          strobe_b_reg;

   logic          baud_done;
   logic          pop;
   logic          wr_data, wr_status, sel_status;
   logic [7:0]    fifo_dout;
   logic          fifo_empty, fifo_full;
   logic [CW-1:0] fifo_count;
   logic [31:0]   status_word;
   logic          unused_bits;

   assign unused_bits = ^bus.data_b_in[31:8];

   assign sel_status = (bus.addr_b == ADDR_STATUS);
   assign wr_data    = bus.data_b_we & (bus.addr_b == ADDR_DATA);
   assign wr_status  = bus.data_b_we & sel_status;

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_data),
      .pop   (pop),
      .din   (bus.data_b_in[7:0]),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   // A drop happens only when full and nothing leaves this cycle; set beats clear.
   always_comb begin
      overflow_next = overflow_reg;
      if (wr_data && fifo_full && !pop) overflow_next = 1'b1;
      else if (wr_status)               overflow_next = 1'b0;
   end

   always_comb begin
      status_word                                 = '0;
      status_word[ST_EMPTY]                       = fifo_empty;
      status_word[ST_FULL]                        = fifo_full;
      status_word[ST_OVERFLOW]                    = overflow_reg;
      status_word[ST_ACTIVE]                      = (state_reg != TX_IDLE);
      status_word[ST_COUNT_LSB +: ST_COUNT_W]     = ST_COUNT_W'(fifo_count);
   end

   assign baud_done = (baud_reg == BAUD_LAST);

   // Next-state logic. STOP pops straight into START so frames are contiguous.
   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      pop        = 1'b0;
      case (state_reg)
         TX_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_next = fifo_dout;
               baud_next  = '0;
               bit_next   = '0;
               state_next = TX_START;
            end
         end
         TX_START: begin
            if (baud_done) begin
               baud_next  = '0;
               state_next = TX_DATA;
            end else begin
               baud_next  = baud_reg + BW'(1);
            end
         end
         TX_DATA: begin
            if (baud_done) begin
               baud_next  = '0;
               shift_next = {1'b0, shift_reg[7:1]};
               if (bit_reg == 3'd7) state_next = TX_STOP;
               else                 bit_next   = bit_reg + 3'd1;
            end else begin
               baud_next  = baud_reg + BW'(1);
            end
         end
         TX_STOP: begin
            if (baud_done) begin
               baud_next = '0;
               bit_next  = '0;
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  shift_next = fifo_dout;
                  state_next = TX_START;
               end else begin
                  state_next = TX_IDLE;
               end
            end else begin
               baud_next = baud_reg + BW'(1);
            end
         end
         default: state_next = TX_IDLE;
      endcase
   end

   // Line level is decoded from the upcoming state so the registered tx
   // changes on the same edge as the state, with no combinational path out.
   always_comb begin
      tx_next = 1'b1;
      case (state_next)
         TX_START: tx_next = 1'b0;
         TX_DATA:  tx_next = shift_next[0];
         default:  tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= TX_IDLE;
         baud_reg     <= '0;
         bit_reg      <= '0;
         shift_reg    <= '0;
         tx_reg       <= 1'b1;
         overflow_reg <= 1'b0;
         data_b_reg   <= '0;
         strobe_b_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         baud_reg     <= baud_next;
         bit_reg      <= bit_next;
         shift_reg    <= shift_next;
         tx_reg       <= tx_next;
         overflow_reg <= overflow_next;
         data_b_reg   <= sel_status ? status_word : 32'd0;
         strobe_b_reg <= sel_status;
      end
   end

   assign tx           = tx_reg;
   assign busy         = (state_reg != TX_IDLE) | ~fifo_empty;
   assign bus.data_b   = data_b_reg;
   assign bus.strobe_b = strobe_b_reg;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio with CLK_DIV=4, FIFO_DEPTH=4.
// A line monitor decodes 8N1 frames from tx by mid-bit sampling; decoded
// bytes and frame start cycles are compared with the bytes the bench expects.
module tb_uart_tx_mmio;
   import soc_mmio_pkg::*;

   localparam int DIV   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * DIV;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic tx, busy;

   uart_tx_mmio_if bus_if ();

   uart_tx_mmio #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus_if),
      .tx   (tx),
      .busy (busy)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   byte unsigned mon_data [$];
   int unsigned  mon_start[$];
   logic         mon_stop [$];
   byte unsigned exp_q    [$];
   logic         mon_prev = 1'b1;

   // Line monitor: k counts negedges from the first low sample of a start bit.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && mon_prev === 1'b1 && tx === 1'b0) begin
            byte unsigned got;
            logic         stopb;
            logic         ok;
            int unsigned  st;
            got = 0; stopb = 1'b0; ok = 1'b1; st = cyc;
            for (int k = 1; k <= 9 * DIV + DIV / 2; k++) begin
               @(negedge clk);
               if (rst !== 1'b1) ok = 1'b0;
               for (int i = 0; i < 8; i++)
                  if (k == DIV * (1 + i) + DIV / 2) got[i] = tx;
               if (k == 9 * DIV + DIV / 2) stopb = tx;
            end
            if (ok) begin
               mon_data.push_back(got);
               mon_start.push_back(st);
               mon_stop.push_back(stopb);
            end
         end
         mon_prev = tx;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus_if.addr_b    = a;
      bus_if.data_b_in = d;
      bus_if.data_b_we = 1'b1;
      @(negedge clk);
      bus_if.data_b_we = 1'b0;
      bus_if.addr_b    = 32'd0;
   endtask

   task automatic write_byte(input byte unsigned b);
      exp_q.push_back(b);
      bus_write(ADDR_DATA, {24'd0, b});
   endtask

   task automatic read_status(input string tag, input logic [31:0] exp);
      bus_if.addr_b    = ADDR_STATUS;
      bus_if.data_b_we = 1'b0;
      @(negedge clk);
      chk({tag, "_data_b"}, bus_if.data_b, exp);
      chk({tag, "_strobe_b"}, {31'd0, bus_if.strobe_b}, 32'd1);
      bus_if.addr_b = 32'd0;
   endtask

   // Waits (bounded) for n decoded frames; checks bytes, stop bits, contiguity.
   task automatic check_line(input string tag, input int n);
      int          budget;
      int unsigned prev_st;
      budget  = n * FRAME + 60;
      prev_st = 0;
      while (mon_data.size() < n && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk({tag, "_frames"}, mon_data.size(), n);
      for (int i = 0; i < n; i++) begin
         if (mon_data.size() == 0 || exp_q.size() == 0) break;
         chk($sformatf("%s_byte%0d", tag, i), {24'd0, mon_data.pop_front()}, {24'd0, exp_q.pop_front()});
         chk($sformatf("%s_stop%0d", tag, i), {31'd0, mon_stop.pop_front()}, 32'd1);
         if (i > 0) chk($sformatf("%s_gap%0d", tag, i), mon_start[0] - prev_st, FRAME);
         prev_st = mon_start.pop_front();
      end
   endtask

   initial begin
      logic [9:0] frame_bits;
      int         lows;
      bus_if.addr_b    = 32'd0;
      bus_if.data_b_in = 32'd0;
      bus_if.data_b_we = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_data_b", bus_if.data_b, 32'd0);
      chk("rst_strobe_b", {31'd0, bus_if.strobe_b}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // 1: status after reset is empty only
      read_status("t1", 32'h001);
      @(negedge clk);
      chk("t1_strobe_clear", {31'd0, bus_if.strobe_b}, 32'd0);
      chk("t1_data_clear", bus_if.data_b, 32'd0);

      // 2: single frame, cycle-exact waveform
      write_byte(8'h55);
      chk("t2_tx_before_start", {31'd0, tx}, 32'd1);
      chk("t2_busy_queued", {31'd0, busy}, 32'd1);
      frame_bits = {1'b1, 8'h55, 1'b0};
      for (int k = 0; k < FRAME; k++) begin
         @(negedge clk);
         chk($sformatf("t2_wave%0d", k), {31'd0, tx}, {31'd0, frame_bits[k / DIV]});
      end
      chk("t2_busy_last_stop", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("t2_busy_done", {31'd0, busy}, 32'd0);
      chk("t2_tx_idle", {31'd0, tx}, 32'd1);
      check_line("t2", 1);

      // 3: two back-to-back frames
      write_byte(8'hA5);
      write_byte(8'h3C);
      check_line("t3", 2);
      repeat (4) @(negedge clk);

      // 4: overflow on the sixth byte
      for (int i = 1; i <= 6; i++) begin
         if (i <= 5) exp_q.push_back(byte'(i));
         bus_write(ADDR_DATA, i);
      end
      read_status("t4", 32'h04E);

      // 5: clearing overflow leaves the other fields alone
      bus_write(ADDR_STATUS, 32'd0);
      read_status("t5", 32'h04A);
      check_line("t4", 5);
      repeat (60) @(negedge clk);
      chk("t4_no_extra", mon_data.size(), 0);
      read_status("t4_drained", 32'h001);

      // Randomized bursts that never overflow (at most one popped + DEPTH queued)
      for (int r = 0; r < 6; r++) begin
         int len;
         len = $urandom_range(1, DEPTH + 1);
         for (int i = 0; i < len; i++) begin
            write_byte(byte'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 1)) @(negedge clk);
         end
         check_line($sformatf("rnd%0d", r), len);
         repeat (4) @(negedge clk);
         chk($sformatf("rnd%0d_busy", r), {31'd0, busy}, 32'd0);
         read_status($sformatf("rnd%0d", r), 32'h001);
      end

      // 6: reset during data bit 3 with two bytes queued
      bus_write(ADDR_DATA, 32'hF0);
      bus_write(ADDR_DATA, 32'h11);
      bus_write(ADDR_DATA, 32'h22);
      repeat (16) @(negedge clk);
      chk("t6_tx_bit3_low", {31'd0, tx}, 32'd0);
      rst = 1'b0;
      #1;
      chk("t6_tx_async", {31'd0, tx}, 32'd1);
      chk("t6_busy_async", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      read_status("t6", 32'h001);
      lows = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("t6_line_quiet", lows, 0);
      chk("t6_no_frames", mon_data.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped serial transmitter on the CPU data-bus port B, sitting beside `ledwriter` and `socram` in the I/O address space above 0xFFFF. Software writes bytes to a data register. They are queued in a small FIFO and shifted out as 8N1 frames (1 start, 8 data LSB-first, 1 stop) on `tx`. A status register is readable through the same registered `data_b`/`strobe_b` read convention as `socram`, so the CPU can poll for space and for completion.

## Interface
- `CLK_DIV`, 434: clock cycles per serial bit (50 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 16: FIFO entries; must be a power of two, ≥ 2.
- `ADDR_DATA`, 65544: write address of the TX data register.
- `ADDR_STATUS`, 65548: read address of the status register; a write to it clears overflow.
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, asynchronous, active-low.
- `addr_b` in 32: bus address.
- `data_b_in` in 32: write data; only [7:0] is used.
- `data_b_we` in 1: write enable.
- `data_b` out 32: registered read data.
- `strobe_b` out 1: registered; high when the previous-cycle address was `ADDR_STATUS`.
- `tx` out 1: serial line; idles high.
- `busy` out 1: high when the FIFO is non-empty or a frame is in progress.

## Operation
- **Push.** When `data_b_we` is high and `addr_b == ADDR_DATA`:
  - If the FIFO is not full, push `data_b_in[7:0]`.
  - If the FIFO is full, drop the byte and set the sticky `overflow` flag.
  - Full with a pop in the same cycle: the push is accepted and the count is unchanged.
- **Clear.** A write with `addr_b == ADDR_STATUS` clears `overflow`. If an overflow occurs in the same cycle, set wins.
- **Status word** (bits [31:9] = 0):
  - bit 0: empty
  - bit 1: full
  - bit 2: overflow
  - bit 3: FSM not IDLE
  - bits [8:4]: FIFO count
- **Read path.** Every edge loads `data_b` with the status word if `addr_b == ADDR_STATUS`, else 0. `strobe_b` is loaded with `(addr_b == ADDR_STATUS)`. Reads have no side effects.
- **FSM states:** IDLE, START, DATA, STOP. Baud counter runs 0..CLK_DIV-1; bit index runs 0..7.
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx` = 0 for CLK_DIV cycles, then go to DATA.
  - DATA: `tx` = shift[0]; after CLK_DIV cycles shift right. After bit 7, go to STOP.
  - STOP: `tx` = 1 for CLK_DIV cycles. Then, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- **Output registering.** `tx` is registered and glitch-free.
- **`busy`** = (state != IDLE) | !empty.

## Timing
- **Reset values** (while `rst` is low, applied immediately): `tx`=1, `data_b`=0, `strobe_b`=0, `busy`=0, FIFO empty, `overflow`=0, state IDLE, all counters 0.
- **Reset mid-frame:** the frame is aborted, `tx` goes high at once, and queued bytes are discarded.
- **Write to line:** a write sampled at edge E makes count=1 after E. `tx` falls after edge E+1.
- **Frame length:** exactly 10·CLK_DIV cycles. Back-to-back frames are contiguous.
- **`busy`** falls on the edge that ends the final stop bit, when the FIFO is empty.
- **Read latency:** `data_b`/`strobe_b` are valid one cycle after the address is presented.
- **FIFO count:** wraps correctly at FIFO_DEPTH. Pointers are log2(FIFO_DEPTH) bits; the count is one bit wider.

## Structure
- **Shared package `soc_mmio_pkg`:**
  - `ADDR_DATA`/`ADDR_STATUS` constants
  - status bit indices
  - FSM state enum
- **Sub-module `uart_tx_fifo`:** synchronous FIFO with ports push, pop, din[7:0], dout[7:0], empty, full, count. It supports simultaneous push and pop when full.

## Test plan
Use CLK_DIV=4, FIFO_DEPTH=4.
1. Reset then read `ADDR_STATUS` → `tx`=1, `busy`=0, `data_b`=0x001, `strobe_b`=1 one cycle later.
2. Write 0x55 → `tx` low 4 cycles; then 1,0,1,0,1,0,1,0 each for 4 cycles; stop high 4 cycles. Total 40 cycles, after which `busy`=0.
3. Write 0xA5 then 0x3C on consecutive cycles → 80 contiguous cycles of two frames with no idle bit between them.
4. Write 6 bytes 0x01–0x06 on consecutive cycles → 0x01 is popped while 0x02 is pushed; 0x02–0x05 fill the FIFO; 0x06 is dropped. Status read = 0x04E. Line carries exactly 0x01–0x05.
5. After test 4, write to `ADDR_STATUS` → next status read has bit 2 = 0; other fields are unchanged.
6. Assert `rst` during data bit 3 of a frame with 2 bytes queued → `tx`=1 immediately. After release, status = 0x001 and no further line activity.
